serial_bit_streamer: RTL and testbench
======================================

Name: serial_bit_streamer

Overview:
- Parallel-in / serial-out stage that sits directly upstream of the serial sequence detector and drives its single-bit serial input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, MSB- or LSB-first.
- Optionally inserts an idle gap of zeros between words.
- Provides framing strobes so the bench and any downstream logic can align detections with word boundaries.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- GAP, 0, number of idle cycles inserted after each word (0..15). During a gap serial_out=0 and serial_valid=0.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- data_in  input  WIDTH  parallel word to serialise.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  block will accept data_in this cycle.
- serial_out  output  1  serial bit stream; feeds the detector's serial input.
- serial_valid  output  1  serial_out carries a word bit this cycle.
- word_start  output  1  one-cycle pulse coincident with the first bit of a word.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; shift register, bit counter and gap counter cleared.
  - serial_out=0, serial_valid=0, word_start=0, word_done=0, busy=0.
  - data_ready=1 from the first cycle after reset release.
  - Reset mid-word aborts the word; no remaining bits are emitted.
- States IDLE, SHIFT, GAP; state register plus combinational next-state logic.
- Handshake and data_ready:
  - A word is accepted on a rising edge where data_valid && data_ready.
  - data_ready = (state==IDLE) || (state==SHIFT && bit_cnt==WIDTH-1 && GAP==0).
  - data_valid while data_ready=0 is ignored; data_in is not captured and the source must hold it.
- IDLE:
  - serial_out=0, serial_valid=0.
  - On accept: load the shift register with data_in, set bit_cnt=0, go to SHIFT.
- SHIFT:
  - serial_valid=1; serial_out = shift_reg[WIDTH-1] if MSB_FIRST, else shift_reg[0].
  - Each cycle: shift by one toward the output end, zero-fill, bit_cnt+1.
  - word_start=1 when bit_cnt==0; word_done=1 when bit_cnt==WIDTH-1.
  - After the last bit:
    - GAP>0: go to GAP with gap_cnt=0.
    - GAP==0 and a new accept on the same edge: reload and stay in SHIFT with bit_cnt=0. No bubble; serial_valid stays high.
    - Otherwise: go to IDLE.
- GAP:
  - serial_out=0, serial_valid=0, busy=1.
  - gap_cnt increments each cycle; go to IDLE when gap_cnt==GAP-1, giving exactly GAP idle cycles.
- Latency: word accepted at edge k; first bit is on serial_out in the cycle after edge k; last bit in the cycle after edge k+WIDTH-1.
- All outputs are registered or decoded from registered state; no combinational path from data_valid to serial_out.
- bit_cnt width = clog2(WIDTH); gap_cnt is 4 bits; counters never wrap in normal operation.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=0: send 8'hD0 -> serial_out over 8 cycles = 1,1,0,1,0,0,0,0; word_start on cycle 1; word_done on cycle 8. Chained detector asserts detection once.
- Back-to-back: data_valid held high with 8'hD0 then 8'hFF -> 16 consecutive serial_valid cycles, no bubble; data_ready high in IDLE and on bit 8 only.
- GAP=3: send 8'hA5 then 8'h5A -> after A5's last bit, exactly 3 cycles of serial_valid=0 and serial_out=0, then data_ready=1 and 5A begins.
- MSB_FIRST=0: send 8'h0B -> serial_out = 1,1,0,1,0,0,0,0 (LSB first).
- Reset mid-word: reset_n=0 during bit 4 of 8'hFF -> next cycle serial_out=0, serial_valid=0, state IDLE, data_ready=1. The rest of the word is never emitted.
- Source stall: data_valid=1 while busy in the GAP state -> no capture; data_in changes are ignored until data_ready=1.

Source files
------------

// File: rtl/serial_bit_streamer.sv
// Parallel-in / serial-out stage: takes WIDTH-bit words over valid/ready and
// emits them one bit per clock, with optional idle gap and framing strobes.
module serial_bit_streamer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_start,
  output logic             word_done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               last_bit;
  logic               accept;
  logic [WIDTH-1:0]   shifted;

  // Outputs are pure decodes of registered state, so data_valid never reaches serial_out.
  always_comb begin
    last_bit     = (state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST);
    data_ready   = (state_q == S_IDLE) || (last_bit && (GAP == 0));
    accept       = data_valid && data_ready;
    serial_valid = (state_q == S_SHIFT);
    serial_out   = serial_valid && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    word_start   = serial_valid && (bit_cnt_q == '0);
    word_done    = last_bit;
    busy         = (state_q != S_IDLE);
    shifted      = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d   = shifted;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          bit_cnt_d = '0;
          if (GAP > 0) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else if (accept) begin
            shift_d = data_in;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the shift register is
  // cleared on reset as well so an aborted word leaves no stale bits behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_streamer.sv
// Directed bench for serial_bit_streamer: three instances cover GAP=0 MSB-first,
// GAP=3 MSB-first and GAP=0 LSB-first.
module tb_serial_bit_streamer;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [7:0] din_a, din_b, din_c;
  logic       dv_a, dv_b, dv_c;
  logic       rdy_a, so_a, sv_a, ws_a, wd_a, busy_a;
  logic       rdy_b, so_b, sv_b, ws_b, wd_b, busy_b;
  logic       rdy_c, so_c, sv_c, ws_c, wd_c, busy_c;

  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u_a (
    .clk(clk), .reset_n(reset_n), .data_in(din_a), .data_valid(dv_a),
    .data_ready(rdy_a), .serial_out(so_a), .serial_valid(sv_a),
    .word_start(ws_a), .word_done(wd_a), .busy(busy_a));

  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3)) u_b (
    .clk(clk), .reset_n(reset_n), .data_in(din_b), .data_valid(dv_b),
    .data_ready(rdy_b), .serial_out(so_b), .serial_valid(sv_b),
    .word_start(ws_b), .word_done(wd_b), .busy(busy_b));

  serial_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u_c (
    .clk(clk), .reset_n(reset_n), .data_in(din_c), .data_valid(dv_c),
    .data_ready(rdy_c), .serial_out(so_c), .serial_valid(sv_c),
    .word_start(ws_c), .word_done(wd_c), .busy(busy_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  w8;
  logic [15:0] w16;

  initial begin
    reset_n = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    dv_a = 1'b0; dv_b = 1'b0; dv_c = 1'b0;
    step();
    step();
    check("rst_sv", {7'd0, sv_a}, 8'd0);
    check("rst_so", {7'd0, so_a}, 8'd0);
    check("rst_busy", {7'd0, busy_a}, 8'd0);
    check("rst_ws_wd", {6'd0, ws_a, wd_a}, 8'd0);
    reset_n = 1'b1;
    step();
    check("rst_ready", {5'd0, rdy_a, rdy_b, rdy_c}, 8'h07);

    // Single word D0, MSB first, no gap.
    w8 = 8'hD0;
    din_a = w8; dv_a = 1'b1;
    step();
    dv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("a_bit", {7'd0, so_a}, {7'd0, w8[7-i]});
      check("a_sv", {7'd0, sv_a}, 8'd1);
      check("a_ws", {7'd0, ws_a}, {7'd0, i == 0});
      check("a_wd", {7'd0, wd_a}, {7'd0, i == 7});
      check("a_rdy", {7'd0, rdy_a}, {7'd0, i == 7});
      step();
    end
    check("a_end_sv", {7'd0, sv_a}, 8'd0);
    check("a_end_busy", {7'd0, busy_a}, 8'd0);
    check("a_end_rdy", {7'd0, rdy_a}, 8'd1);

    // Back-to-back D0 then FF with valid held high: 16 bits, no bubble.
    w16 = 16'hD0FF;
    din_a = 8'hD0; dv_a = 1'b1;
    step();
    din_a = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      check("b2b_bit", {7'd0, so_a}, {7'd0, w16[15-i]});
      check("b2b_sv", {7'd0, sv_a}, 8'd1);
      check("b2b_rdy", {7'd0, rdy_a}, {7'd0, (i == 7) || (i == 15)});
      check("b2b_ws", {7'd0, ws_a}, {7'd0, (i == 0) || (i == 8)});
      step();
      if (i == 7) dv_a = 1'b0;
    end
    check("b2b_end_sv", {7'd0, sv_a}, 8'd0);

    // GAP=3: A5 then 5A, with the source stalling and wiggling data during the gap.
    w8 = 8'hA5;
    din_b = w8; dv_b = 1'b1;
    step();
    din_b = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      check("g_a5_bit", {7'd0, so_b}, {7'd0, w8[7-i]});
      check("g_a5_rdy", {7'd0, rdy_b}, 8'd0);
      step();
    end
    for (int g = 0; g < 3; g++) begin
      din_b = (g < 2) ? 8'h33 : 8'h5A;
      check("gap_sv", {7'd0, sv_b}, 8'd0);
      check("gap_so", {7'd0, so_b}, 8'd0);
      check("gap_busy", {7'd0, busy_b}, 8'd1);
      check("gap_rdy", {7'd0, rdy_b}, 8'd0);
      step();
    end
    check("gap_idle_rdy", {7'd0, rdy_b}, 8'd1);
    check("gap_idle_sv", {7'd0, sv_b}, 8'd0);
    step();
    dv_b = 1'b0;
    w8 = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      check("g_5a_bit", {7'd0, so_b}, {7'd0, w8[7-i]});
      check("g_5a_sv", {7'd0, sv_b}, 8'd1);
      check("g_5a_ws", {7'd0, ws_b}, {7'd0, i == 0});
      step();
    end
    for (int g = 0; g < 3; g++) begin
      check("gap2_busy", {7'd0, busy_b}, 8'd1);
      step();
    end
    check("gap2_done", {6'd0, busy_b, sv_b}, 8'd0);

    // LSB first: 0B -> 1,1,0,1,0,0,0,0.
    w8 = 8'h0B;
    din_c = w8; dv_c = 1'b1;
    step();
    dv_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit", {7'd0, so_c}, {7'd0, w8[i]});
      check("lsb_wd", {7'd0, wd_c}, {7'd0, i == 7});
      step();
    end
    check("lsb_end_sv", {7'd0, sv_c}, 8'd0);

    // Reset during the fourth bit of FF aborts the word.
    din_a = 8'hFF; dv_a = 1'b1;
    step();
    dv_a = 1'b0;
    step();
    step();
    step();
    check("mid_bit4", {6'd0, sv_a, so_a}, 8'h03);
    reset_n = 1'b0;
    step();
    check("mid_rst_out", {5'd0, so_a, sv_a, busy_a}, 8'd0);
    check("mid_rst_rdy", {7'd0, rdy_a}, 8'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("mid_no_tail", {6'd0, sv_a, so_a}, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
